// File: rtl/ysyx_22050368_imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder.
// These are the default bus widths, the error-return instruction and the FSM
// state encoding. They also cover the LFSR constants used by the optional
// randomized-latency build (YSYX_22050368_IMEM_LFSR_LAT_EN).
package ysyx_22050368_imem_resp_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;

  // Canonical RISC-V nop (addi x0, x0, 0), returned on any faulting fetch.
  localparam logic [31:0] IMEM_NOP_INST = 32'h0000_0013;

  // Width of the latency down-counter.
  // It comfortably covers LATENCY plus the largest LFSR extension.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1.
  // With a left shift, the feedback is the XOR of bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ysyx_22050368_imem_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when adv_i is high.
// Only the two low bits leave the block; they extend the fetch latency.
module ysyx_22050368_imem_lfsr
  import ysyx_22050368_imem_resp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  output logic [1:0] low_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Step the sequence once per accepted fetch.
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // State register, restarting from the fixed seed on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign low_o = lfsr_q[1:0];

endmodule

// File: rtl/ysyx_22050368_imem_resp.sv
// Instruction-memory responder: memory-side end of the fetch interface.
// It takes one PC request at a time and answers after a programmable latency.
// The response is held until the fetch side takes it.
// The backing word array is filled through a dedicated program-load port.
//
// Optional build macro: YSYX_22050368_IMEM_LFSR_LAT_EN
//   defined   -> per-request latency is LATENCY + lfsr[1:0]
//   undefined -> fixed LATENCY, no LFSR present
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request (req_ready_o high)
// WAIT  | request latched, latency counter running down to zero
// RESP  | response presented, waiting for resp_ready_i
module ysyx_22050368_imem_resp
  import ysyx_22050368_imem_resp_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(IMEM_NOP_INST)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_inst_o,
  output logic              resp_err_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(LATENCY);

  // A byte address is unusable if it is misaligned, or below the window, or
  // beyond the last word. Fetches and program-load writes share this rule.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  imem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] resp_inst_q, resp_inst_d;
  logic              resp_err_q, resp_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bad;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        lat_extra;
  logic [CNT_W-1:0]  eff_lat;

  assign accept = (state_q == ST_IDLE) && req_valid_i;

`ifdef YSYX_22050368_IMEM_LFSR_LAT_EN
  ysyx_22050368_imem_lfsr u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv_i (accept),
    .low_o (lat_extra)
  );
`else
  assign lat_extra = 2'd0;
`endif

  assign eff_lat = LAT_C + CNT_W'(lat_extra);

  // The word is sampled on the edge that enters RESP.
  // With a one-cycle latency, that is the accept edge itself, so the live
  // request address is used. Otherwise the latched address is used.
  assign rd_addr = (state_q == ST_IDLE) ? req_addr_i : addr_q;
  assign rd_bad  = addr_bad(rd_addr);
  assign rd_data = mem_q[addr_idx(rd_addr)];

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_inst_o  = resp_inst_q;
  assign resp_err_o   = resp_err_q;

  // Next-state logic: accept, count the latency down, present and hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    resp_inst_d = resp_inst_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr_i;
          if (eff_lat == CNT_W'(1)) begin
            state_d     = ST_RESP;
            resp_inst_d = rd_bad ? NOP_INST : rd_data;
            resp_err_d  = rd_bad;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = eff_lat - CNT_W'(2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          resp_inst_d = rd_bad ? NOP_INST : rd_data;
          resp_err_d  = rd_bad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers.
  // The response data keeps its last value after the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      resp_inst_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      resp_inst_q <= resp_inst_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Program-load port.
  // The array is not reset, so program contents survive a fetch-side reset.
  // Bad addresses are dropped rather than aliased onto a real word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !addr_bad(wr_addr_i)) begin
      mem_q[addr_idx(wr_addr_i)] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_ysyx_22050368_imem_resp.sv
module tb_ysyx_22050368_imem_resp;

  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [31:0] wr_addr, wr_data;

  logic a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_resp_inst;
  logic b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_resp_inst;

  always #5 clk = ~clk;

  ysyx_22050368_imem_resp #(.LATENCY(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
    .resp_inst_o(a_resp_inst), .resp_err_o(a_resp_err),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  ysyx_22050368_imem_resp #(.LATENCY(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_inst_o(b_resp_inst), .resp_err_o(b_resp_err),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word store, per-DUT latency sequence.
  logic [31:0] ref_mem [4096];
  logic [7:0]  lfsr_m  [2];

  function automatic bit model_bad(input logic [31:0] a);
    longint unsigned ua;
    ua = {32'd0, a};
    return (ua % 4 != 0) || (ua < 64'h8000_0000) || ((ua - 64'h8000_0000) / 4 >= 4096);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_lat(input int w, output int lat);
    lat = (w == 0) ? LAT_A : LAT_B;
`ifdef YSYX_22050368_IMEM_LFSR_LAT_EN
    lat += int'(lfsr_m[w][1:0]);
    lfsr_m[w] = {lfsr_m[w][6:0], lfsr_m[w][7] ^ lfsr_m[w][5] ^ lfsr_m[w][4] ^ lfsr_m[w][3]};
`endif
  endtask

  function automatic logic rdy(input int w);  return (w == 0) ? a_req_ready  : b_req_ready;  endfunction
  function automatic logic vld(input int w);  return (w == 0) ? a_resp_valid : b_resp_valid; endfunction
  function automatic logic errf(input int w); return (w == 0) ? a_resp_err   : b_resp_err;   endfunction
  function automatic logic [31:0] inst(input int w); return (w == 0) ? a_resp_inst : b_resp_inst; endfunction

  task automatic set_req(input int w, input logic v, input logic [31:0] ad);
    if (w == 0) begin a_req_valid = v; a_req_addr = ad; end
    else        begin b_req_valid = v; b_req_addr = ad; end
  endtask

  task automatic set_ready(input int w, input logic v);
    if (w == 0) a_resp_ready = v; else b_resp_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    lfsr_m[0] = 8'hA5;
    lfsr_m[1] = 8'hA5;
  endtask

  task automatic mem_write(input logic [31:0] ad, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = ad; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (!model_bad(ad)) ref_mem[model_idx(ad)] = d;
  endtask

  // wr_mode: 0 none, 1 write fetched word one edge before RESP entry,
  // 2 write it on the RESP-entry edge.
  task automatic do_fetch(input int w, input logic [31:0] ad, input int stall,
                          input int wr_mode, input logic [31:0] wd, input string name);
    int lat, n, wr_edge;
    bit exp_err, early_ready;
    logic [31:0] exp_inst;
    total++;
    if (rdy(w) !== 1'b1) begin
      bad++; $display("FAIL %s_idle_ready: got=%b want=1", name, rdy(w));
    end
    model_lat(w, lat);
    exp_err = model_bad(ad);
    wr_edge = 0;
    if (wr_mode == 1 && lat >= 2) wr_edge = lat - 1;
    if (wr_mode == 2) wr_edge = lat;
    if (exp_err) exp_inst = NOP;
    else if (wr_edge != 0 && wr_edge < lat) exp_inst = wd;
    else exp_inst = ref_mem[model_idx(ad)];
    set_ready(w, stall == 0);
    set_req(w, 1'b1, ad);
    n = 0;
    early_ready = 0;
    do begin
      if (wr_edge != 0 && n + 1 == wr_edge) begin
        wr_en = 1'b1; wr_addr = ad; wr_data = wd;
      end
      @(posedge clk); #1;
      n++;
      if (n == 1) set_req(w, 1'b0, $urandom);
      if (wr_edge != 0 && n == wr_edge) wr_en = 1'b0;
      if (!vld(w) && rdy(w)) early_ready = 1;
    end while (!vld(w) && n < lat + 8);
    wr_en = 1'b0;
    if (wr_edge != 0 && !exp_err) ref_mem[model_idx(ad)] = wd;
    total++;
    if (vld(w) !== 1'b1) begin
      bad++; $display("FAIL %s_timeout: resp_valid=%b after %0d edges", name, vld(w), n);
      set_ready(w, 1'b1);
      return;
    end
    total++;
    if (n != lat) begin
      bad++; $display("FAIL %s_latency: got=%0d want=%0d", name, n, lat);
    end
    total++;
    if (early_ready || rdy(w) !== 1'b0) begin
      bad++; $display("FAIL %s_busy_ready: req_ready high while busy", name);
    end
    total++;
    if (inst(w) !== exp_inst || errf(w) !== exp_err) begin
      bad++; $display("FAIL %s_data: got=%h/%b want=%h/%b", name, inst(w), errf(w), exp_inst, exp_err);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      total++;
      if (vld(w) !== 1'b1 || rdy(w) !== 1'b0 || inst(w) !== exp_inst || errf(w) !== exp_err) begin
        bad++; $display("FAIL %s_hold%0d: valid=%b ready=%b inst=%h want %h", name, s, vld(w), rdy(w), inst(w), exp_inst);
      end
    end
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    total++;
    if (vld(w) !== 1'b0 || rdy(w) !== 1'b1 || inst(w) !== exp_inst || errf(w) !== exp_err) begin
      bad++; $display("FAIL %s_release: valid=%b ready=%b inst=%h want valid=0 ready=1 inst=%h", name, vld(w), rdy(w), inst(w), exp_inst);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int w = 0; w < 2; w++) begin
      total++;
      if (rdy(w) !== 1'b1) begin bad++; $display("FAIL reset_ready%0d: got=%b want=1", w, rdy(w)); end
      total++;
      if (vld(w) !== 1'b0) begin bad++; $display("FAIL reset_valid%0d: got=%b want=0", w, vld(w)); end
      total++;
      if (inst(w) !== 32'h0 || errf(w) !== 1'b0) begin
        bad++; $display("FAIL reset_resp%0d: got=%h/%b want=0/0", w, inst(w), errf(w));
      end
    end
  endtask

  task automatic test_preload();
    mem_write(32'h8000_0000, 32'h0010_0093);
    mem_write(32'h8000_0004, 32'hDEAD_BEEF);
    mem_write(32'h8000_0008, 32'hCAFE_F00D);
    for (int i = 3; i < 32; i++) mem_write(BASE + 32'(i * 4), $urandom);
    mem_write(32'h8000_3FFC, 32'h0BAD_CAFE);
  endtask

  task automatic test_basic();
    do_fetch(0, 32'h8000_0000, 0, 0, 0, "lat1_basic");
    do_fetch(1, 32'h8000_0004, 5, 0, 0, "lat3_stall");
  endtask

  task automatic test_errors();
    do_fetch(1, 32'h8000_0002, 0, 0, 0, "err_misaligned");
    do_fetch(0, 32'h7FFF_FFFC, 1, 0, 0, "err_below");
    do_fetch(1, 32'h8000_4000, 0, 0, 0, "err_above");
    do_fetch(0, 32'h8000_3FFC, 0, 0, 0, "last_word");
  endtask

  task automatic test_write_drop();
    mem_write(32'h8000_4000, 32'h1111_1111);
    mem_write(32'h8000_0001, 32'h2222_2222);
    mem_write(32'h7FFF_FFFC, 32'h3333_3333);
    do_fetch(1, 32'h8000_0000, 0, 0, 0, "drop_word0");
  endtask

  task automatic test_wait_write();
    do_fetch(1, 32'h8000_0008, 0, 1, 32'h1234_5678, "wr_in_wait");
    do_fetch(1, 32'h8000_0008, 0, 2, 32'h9ABC_DEF0, "wr_on_entry");
    do_fetch(1, 32'h8000_0008, 0, 0, 0, "wr_after");
  endtask

  task automatic test_reset_mid();
    int lat;
    set_ready(1, 1'b1);
    set_req(1, 1'b1, 32'h8000_0004);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0);
    model_lat(1, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lfsr_m[0] = 8'hA5;
    lfsr_m[1] = 8'hA5;
    total++;
    if (vld(1) !== 1'b0 || rdy(1) !== 1'b1 || inst(1) !== 32'h0) begin
      bad++; $display("FAIL rstmid_state: valid=%b ready=%b inst=%h want 0/1/0", vld(1), rdy(1), inst(1));
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (vld(1) !== 1'b0) begin bad++; $display("FAIL rstmid_spurious: cycle %0d valid=%b want=0", i, vld(1)); end
    end
    do_fetch(1, 32'h8000_0004, 0, 0, 0, "rstmid_refetch");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) do_fetch(0, BASE + 32'(i * 4 + 12), 0, 0, 0, "b2b");
  endtask

  task automatic test_random();
    logic [31:0] ad;
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 6)
        0: ad = BASE + 32'(($urandom % 32) * 4) + 32'($urandom_range(1, 3));
        1: ad = $urandom_range(0, 32'h7FFF_FFFF) & 32'hFFFF_FFFC;
        2: ad = BASE + 32'h4000 + 32'(($urandom % 64) * 4);
        default: ad = BASE + 32'(($urandom % 32) * 4);
      endcase
      do_fetch(int'($urandom % 2), ad, int'($urandom % 3), int'($urandom % 3), $urandom, "rand");
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;
    test_reset();
    test_preload();
    test_basic();
    test_errors();
    test_write_drop();
    test_wait_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22050368_imem_resp.md
Name: ysyx_22050368_imem_resp

Overview:
Instruction-memory responder, the memory-side end of the fetch interface. Accepts one PC fetch request via valid/ready and returns the 32-bit instruction after a programmable latency. The response is held under backpressure. Backed by an internal word array, loadable through a simple write port for program load.

Parameters:
ADDR_W, 32, address width (matches PC width)
DATA_W, 32, instruction width
DEPTH, 4096, number of 32-bit words; power of two
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 1, cycles from request accept to resp_valid; must be >= 1
NOP_INST, 32'h0000_0013, instruction returned on error

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request
req_addr  input  ADDR_W  fetch byte address (PC)
resp_valid  output  1  instruction valid
resp_ready  input  1  fetch side accepts response
resp_inst  output  DATA_W  fetched instruction
resp_err  output  1  misaligned or out-of-range fetch
wr_en  input  1  program-load write strobe
wr_addr  input  ADDR_W  program-load byte address
wr_data  input  DATA_W  program-load word

Behaviour:
- One clock (clk). rst is synchronous, active-high; sampled on the rising edge only.
- Reset values:
  - State is IDLE.
  - req_ready=1 in the cycle after reset.
  - resp_valid=0, resp_inst=0, resp_err=0, latency counter=0.
  - Memory array is NOT reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE), combinational from state only.
- Accept happens on an edge where req_valid & req_ready.
  - Latch req_addr and compute the error flag.
  - LATENCY==1: go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT: cnt decrements each cycle. When cnt==0, go to RESP on the next edge.
- Net effect: resp_valid rises exactly LATENCY edges after the accept edge.
- Memory read is sampled on the edge entering RESP.
  - Index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
- Error rule: resp_err=1 if any of the following holds. In that case resp_inst=NOP_INST.
  - addr[1:0]!=0
  - addr<BASE_ADDR
  - (addr-BASE_ADDR)>>2 >= DEPTH
- RESP:
  - resp_valid=1. resp_inst and resp_err are stable until the handshake.
  - On resp_valid & resp_ready, return to IDLE; resp_valid=0 next cycle. resp_inst and resp_err hold their last value.
- No overlap: at most one outstanding request. Throughput is one fetch per LATENCY+1 cycles with resp_ready tied high.
- Write port:
  - Active in any state; writes the word at the index of wr_addr.
  - Misaligned or out-of-range writes are silently dropped.
  - A write on the same edge as the RESP-entry read is not visible to that read (read-before-write).
  - A write during WAIT to the pending word is visible.
- Reset mid-transaction (WAIT or RESP): the transaction is dropped and the FSM returns to IDLE. Array contents are preserved.
- req_addr changing while req_ready=0 has no effect.

Optional Feature:
- Macro: YSYX_22050368_IMEM_LFSR_LAT_EN
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - Advances once per accepted request.
  - Effective latency for that request = LATENCY + lfsr[1:0], using the value before advancing.
- Undefined: latency is fixed at LATENCY; no LFSR logic is present.

Decomposition:
- Shared package/defines:
  - ADDR_W and DATA_W defaults
  - NOP_INST constant
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - LFSR seed and tap constants
- One sub-module: ysyx_22050368_imem_lfsr (8-bit LFSR with advance enable). Instantiated only under the macro.

Test Plan:
1. Preload 0x80000000←0x00100093, LATENCY=1; request 0x80000000 with resp_ready=1 → resp_valid rises 1 edge after accept, resp_inst=0x00100093, resp_err=0; req_ready back to 1 the cycle after the handshake.
2. LATENCY=3; request 0x80000004 (preloaded 0xDEADBEEF) → resp_valid exactly 3 edges after accept. Hold resp_ready=0 for 5 cycles → resp_inst stays 0xDEADBEEF, req_ready stays 0.
3. Request 0x80000002 → resp_err=1, resp_inst=0x00000013. Request 0x7FFFFFFC and 0x80004000 (DEPTH=4096) → both resp_err=1.
4. LATENCY=3; accept 0x80000008; write 0x80000008←0x12345678 during WAIT → response 0x12345678. Repeat with the write on the RESP-entry edge → old word returned.
5. Assert rst during WAIT → resp_valid=0, req_ready=1 next cycle, no spurious response. Re-fetch of a preloaded word still returns its value.
6. With the macro defined, LATENCY=1, four back-to-back requests after reset → latencies follow 1+lfsr[1:0] from seed 0xA5 (first latency = 2).
